cp0_commit_unit: RTL and testbench

Sequential CP0 state and multi-lane commit unit for the dual-issue MIPS pipeline. It receives NUM_LANES retiring instructions per cycle and applies them in program order: MTC0 writes, exception entry, and ERET. It owns the Count/Compare timer and a synchronised external-interrupt path, and produces a registered interrupt request and a one-cycle pipeline redirect (flush) with its target PC. GPR and HI/LO writeback stay outside this block; it only reports which lanes are squashed.

---
 rtl/cp0_commit_unit_pkg.sv | 81 ++++++++
 rtl/cp0_commit_unit_if.sv | 33 +++
 rtl/cp0_commit_unit_timer.sv | 60 ++++++
 rtl/cp0_commit_unit.sv | 228 ++++++++++++++++++++++
 tb/tb_cp0_commit_unit.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cp0_commit_unit_pkg.sv
// Shared CP0 types, register numbers and exception vector helper for the
// dual-issue commit unit.
package cp0_commit_unit_pkg;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;
  localparam logic [4:0] CP0_ERROREPC = 5'd30;

  localparam logic [31:0] STATUS_RESET  = 32'h0040_0000;
  localparam logic [31:0] STATUS_WMASK  = 32'h0040_FF07;
  localparam logic [31:0] VEC_BASE_BEV  = 32'hBFC0_0200;
  localparam logic [31:0] VEC_BASE_NORM = 32'h8000_0000;
  localparam logic [31:0] VEC_OFF_GEN   = 32'h0000_0180;
  localparam logic [31:0] VEC_OFF_INT   = 32'h0000_0200;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  typedef struct packed {
    logic [8:0] rsvd_hi;
    logic       bev;
    logic [5:0] rsvd_mid;
    logic [7:0] im;
    logic [4:0] rsvd_lo;
    logic       erl;
    logic       exl;
    logic       ie;
  } status_t;

  typedef struct packed {
    logic       bd;
    logic       ti;
    logic [5:0] rsvd0;
    logic       iv;
    logic [6:0] rsvd1;
    logic [7:0] ip;
    logic       rsvd2;
    logic [4:0] exc_code;
    logic [1:0] rsvd3;
  } cause_t;

  typedef struct packed {
    logic        valid;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic        delayed;
    logic [31:0] pc;
    logic        bad_vaddr_valid;
    logic [31:0] bad_vaddr;
    logic        eret;
    logic        mtc0;
    logic [4:0]  mtc0_dst;
    logic [31:0] mtc0_value;
  } lane_commit_t;

  function automatic logic [31:0] exc_vector(input logic bev, input logic [4:0] code,
                                             input logic iv);
    logic [31:0] base;
    logic [31:0] off;
    base = bev ? VEC_BASE_BEV : VEC_BASE_NORM;
    off  = ((code == 5'(EXC_INT)) && iv) ? VEC_OFF_INT : VEC_OFF_GEN;
    return base + off;
  endfunction

  // Only BEV, IM, ERL, EXL and IE are writable; reserved bits keep their value.
  function automatic status_t status_write(input status_t cur, input logic [31:0] val);
    return status_t'((val & STATUS_WMASK) | (32'(cur) & ~STATUS_WMASK));
  endfunction

endpackage

// File: rtl/cp0_commit_unit_if.sv
// Commit-lane bus from the retire stage and the redirect/squash response.
interface cp0_commit_unit_if #(parameter int NUM_LANES = 2);

  logic [NUM_LANES-1:0]    lane_valid;
  logic [NUM_LANES-1:0]    lane_exc_valid;
  logic [NUM_LANES*5-1:0]  lane_exc_code;
  logic [NUM_LANES-1:0]    lane_delayed;
  logic [NUM_LANES*32-1:0] lane_pc;
  logic [NUM_LANES-1:0]    lane_bad_vaddr_valid;
  logic [NUM_LANES*32-1:0] lane_bad_vaddr;
  logic [NUM_LANES-1:0]    lane_eret;
  logic [NUM_LANES-1:0]    lane_mtc0;
  logic [NUM_LANES*5-1:0]  lane_mtc0_dst;
  logic [NUM_LANES*32-1:0] lane_mtc0_value;
  logic [NUM_LANES-1:0]    lane_squash;
  logic                    flush_valid;
  logic [31:0]             flush_pc;

  modport master (
    output lane_valid, lane_exc_valid, lane_exc_code, lane_delayed, lane_pc,
           lane_bad_vaddr_valid, lane_bad_vaddr, lane_eret, lane_mtc0,
           lane_mtc0_dst, lane_mtc0_value,
    input  lane_squash, flush_valid, flush_pc
  );

  modport slave (
    input  lane_valid, lane_exc_valid, lane_exc_code, lane_delayed, lane_pc,
           lane_bad_vaddr_valid, lane_bad_vaddr, lane_eret, lane_mtc0,
           lane_mtc0_dst, lane_mtc0_value,
    output lane_squash, flush_valid, flush_pc
  );

endinterface

// File: rtl/cp0_commit_unit_timer.sv
// Count/Compare timer with a clock divider and the sticky timer-interrupt flag.
module cp0_commit_unit_timer #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wr_count,
  input  logic [31:0] wr_count_val,
  input  logic        wr_compare,
  input  logic [31:0] wr_compare_val,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

  logic [DIV_W-1:0] tick_cnt_r, tick_cnt_n_s;
  logic             tick_s;
  logic [31:0]      count_r, count_n_s, count_inc_s;
  logic [31:0]      compare_r, compare_n_s;
  logic             ti_r, ti_n_s;

  // Next-state: divider, Count increment/override, TI set/clear (clear wins).
  always_comb begin
    tick_s       = (tick_cnt_r == DIV_LAST);
    tick_cnt_n_s = tick_s ? '0 : tick_cnt_r + DIV_W'(1);
    count_inc_s  = count_r + 32'd1;
    count_n_s    = wr_count ? wr_count_val : (tick_s ? count_inc_s : count_r);
    compare_n_s  = wr_compare ? wr_compare_val : compare_r;
    if (wr_compare) begin
      ti_n_s = 1'b0;
    end else if (tick_s && !wr_count && (count_inc_s == compare_r)) begin
      ti_n_s = 1'b1;
    end else begin
      ti_n_s = ti_r;
    end
  end

  // Timer state registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tick_cnt_r <= '0;
      count_r    <= 32'd0;
      compare_r  <= 32'd0;
      ti_r       <= 1'b0;
    end else begin
      tick_cnt_r <= tick_cnt_n_s;
      count_r    <= count_n_s;
      compare_r  <= compare_n_s;
      ti_r       <= ti_n_s;
    end
  end

  assign count   = count_r;
  assign compare = compare_r;
  assign ti      = ti_r;

endmodule

// File: rtl/cp0_commit_unit.sv
// CP0 state and in-order multi-lane commit: MTC0, exception entry, ERET,
// interrupt request and one-cycle pipeline redirect.
module cp0_commit_unit
  import cp0_commit_unit_pkg::*;
#(
  parameter int NUM_LANES   = 2,
  parameter int COUNT_DIV   = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [5:0]        ext_int,
  input  logic [4:0]        rd_addr,
  output logic [31:0]       rd_data,
  output logic              int_req,
  cp0_commit_unit_if.slave  cbus
);

  localparam int IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  lane_commit_t         lane_s [NUM_LANES];
  logic [NUM_LANES-1:0] squash_s, mtc0_apply_s;
  logic                 win_found_s;
  logic [IDX_W-1:0]     win_idx_s;

  status_t     status_r, status_n_s;
  logic        bd_r, bd_n_s, iv_r, iv_n_s;
  logic [1:0]  ip_sw_r, ip_sw_n_s;
  logic [4:0]  exc_code_r, exc_code_n_s;
  logic [31:0] epc_r, epc_n_s, error_epc_r, error_epc_n_s, bad_vaddr_r, bad_vaddr_n_s;
  logic        flush_valid_r, flush_valid_n_s;
  logic [31:0] flush_pc_r, flush_pc_n_s;
  logic        int_req_r, int_req_n_s;
  logic [5:0]  sync_r [SYNC_STAGES];
  logic [5:0]  ip_hw_r;
  logic [7:0]  ip_s;
  cause_t      cause_s;

  logic        wr_count_s, wr_compare_s;
  logic [31:0] wr_count_val_s, wr_compare_val_s, count_s, compare_s;
  logic        ti_s;

  cp0_commit_unit_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk            (clk),
    .resetn         (resetn),
    .wr_count       (wr_count_s),
    .wr_count_val   (wr_count_val_s),
    .wr_compare     (wr_compare_s),
    .wr_compare_val (wr_compare_val_s),
    .count          (count_s),
    .compare        (compare_s),
    .ti             (ti_s)
  );

  // Unpack the flat lane buses into per-lane records.
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_s[i].valid           = cbus.lane_valid[i];
      lane_s[i].exc_valid       = cbus.lane_exc_valid[i];
      lane_s[i].exc_code        = cbus.lane_exc_code[i*5 +: 5];
      lane_s[i].delayed         = cbus.lane_delayed[i];
      lane_s[i].pc              = cbus.lane_pc[i*32 +: 32];
      lane_s[i].bad_vaddr_valid = cbus.lane_bad_vaddr_valid[i];
      lane_s[i].bad_vaddr       = cbus.lane_bad_vaddr[i*32 +: 32];
      lane_s[i].eret            = cbus.lane_eret[i];
      lane_s[i].mtc0            = cbus.lane_mtc0[i];
      lane_s[i].mtc0_dst        = cbus.lane_mtc0_dst[i*5 +: 5];
      lane_s[i].mtc0_value      = cbus.lane_mtc0_value[i*32 +: 32];
    end
  end

  // Oldest exception/ERET lane wins; younger lanes are squashed, older MTC0s apply.
  always_comb begin
    win_found_s  = 1'b0;
    win_idx_s    = '0;
    squash_s     = '0;
    mtc0_apply_s = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      squash_s[i] = win_found_s;
      if (!win_found_s && lane_s[i].valid && (lane_s[i].exc_valid || lane_s[i].eret)) begin
        win_found_s = 1'b1;
        win_idx_s   = IDX_W'(i);
      end else begin
        mtc0_apply_s[i] = !win_found_s && lane_s[i].valid && lane_s[i].mtc0;
      end
    end
  end

  // Commit next-state: MTC0s in lane order, then the winner's exception or ERET.
  always_comb begin
    status_n_s       = status_r;
    bd_n_s           = bd_r;
    iv_n_s           = iv_r;
    ip_sw_n_s        = ip_sw_r;
    exc_code_n_s     = exc_code_r;
    epc_n_s          = epc_r;
    error_epc_n_s    = error_epc_r;
    bad_vaddr_n_s    = bad_vaddr_r;
    wr_count_s       = 1'b0;
    wr_count_val_s   = count_s;
    wr_compare_s     = 1'b0;
    wr_compare_val_s = compare_s;
    flush_valid_n_s  = 1'b0;
    flush_pc_n_s     = flush_pc_r;
    for (int i = 0; i < NUM_LANES; i++) begin
      // Non-applying lanes select address 0, which matches no writable CP0 register.
      case (mtc0_apply_s[i] ? lane_s[i].mtc0_dst : 5'd0)
        CP0_BADVADDR: bad_vaddr_n_s = lane_s[i].mtc0_value;
        CP0_COUNT: begin
          wr_count_s     = 1'b1;
          wr_count_val_s = lane_s[i].mtc0_value;
        end
        CP0_COMPARE: begin
          wr_compare_s     = 1'b1;
          wr_compare_val_s = lane_s[i].mtc0_value;
        end
        CP0_STATUS: status_n_s = status_write(status_n_s, lane_s[i].mtc0_value);
        CP0_CAUSE: begin
          iv_n_s    = lane_s[i].mtc0_value[23];
          ip_sw_n_s = lane_s[i].mtc0_value[9:8];
        end
        CP0_EPC:      epc_n_s       = lane_s[i].mtc0_value;
        CP0_ERROREPC: error_epc_n_s = lane_s[i].mtc0_value;
        default: ;
      endcase
    end
    if (win_found_s && lane_s[win_idx_s].exc_valid) begin
      epc_n_s = status_r.exl ? epc_n_s
              : (lane_s[win_idx_s].delayed ? lane_s[win_idx_s].pc - 32'd4
                                           : lane_s[win_idx_s].pc);
      bd_n_s        = status_r.exl ? bd_n_s : lane_s[win_idx_s].delayed;
      bad_vaddr_n_s = lane_s[win_idx_s].bad_vaddr_valid ? lane_s[win_idx_s].bad_vaddr
                                                        : bad_vaddr_n_s;
      exc_code_n_s    = lane_s[win_idx_s].exc_code;
      flush_valid_n_s = 1'b1;
      flush_pc_n_s    = exc_vector(status_n_s.bev, lane_s[win_idx_s].exc_code, iv_n_s);
      status_n_s.exl  = 1'b1;
    end else if (win_found_s) begin
      flush_valid_n_s = 1'b1;
      flush_pc_n_s    = status_n_s.erl ? error_epc_n_s : epc_n_s;
      if (status_n_s.erl) begin
        status_n_s.erl = 1'b0;
      end else begin
        status_n_s.exl = 1'b0;
      end
    end else begin
      flush_valid_n_s = 1'b0;
    end
  end

  // Cause view and interrupt request from registered state.
  always_comb begin
    ip_s             = {ip_hw_r[5] | ti_s, ip_hw_r[4:0], ip_sw_r};
    cause_s          = '0;
    cause_s.bd       = bd_r;
    cause_s.ti       = ti_s;
    cause_s.iv       = iv_r;
    cause_s.ip       = ip_s;
    cause_s.exc_code = exc_code_r;
    int_req_n_s      = status_r.ie && !status_r.exl && !status_r.erl
                    && (|(ip_s & status_r.im));
  end

  // MFC0 read mux; unimplemented registers read as zero.
  always_comb begin
    case (rd_addr)
      CP0_BADVADDR: rd_data = bad_vaddr_r;
      CP0_COUNT:    rd_data = count_s;
      CP0_COMPARE:  rd_data = compare_s;
      CP0_STATUS:   rd_data = 32'(status_r);
      CP0_CAUSE:    rd_data = 32'(cause_s);
      CP0_EPC:      rd_data = epc_r;
      CP0_ERROREPC: rd_data = error_epc_r;
      default:      rd_data = 32'd0;
    endcase
  end

  // External interrupt synchroniser feeding the hardware IP bits.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_r[s] <= 6'd0;
      end
      ip_hw_r <= 6'd0;
    end else begin
      sync_r[0] <= ext_int;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_r[s] <= sync_r[s-1];
      end
      ip_hw_r <= sync_r[SYNC_STAGES-1];
    end
  end

  // Architectural CP0 state and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      status_r      <= status_t'(STATUS_RESET);
      bd_r          <= 1'b0;
      iv_r          <= 1'b0;
      ip_sw_r       <= 2'd0;
      exc_code_r    <= 5'd0;
      epc_r         <= 32'd0;
      error_epc_r   <= 32'd0;
      bad_vaddr_r   <= 32'd0;
      flush_valid_r <= 1'b0;
      flush_pc_r    <= 32'd0;
      int_req_r     <= 1'b0;
    end else begin
      status_r      <= status_n_s;
      bd_r          <= bd_n_s;
      iv_r          <= iv_n_s;
      ip_sw_r       <= ip_sw_n_s;
      exc_code_r    <= exc_code_n_s;
      epc_r         <= epc_n_s;
      error_epc_r   <= error_epc_n_s;
      bad_vaddr_r   <= bad_vaddr_n_s;
      flush_valid_r <= flush_valid_n_s;
      flush_pc_r    <= flush_pc_n_s;
      int_req_r     <= int_req_n_s;
    end
  end

  assign int_req          = int_req_r;
  assign cbus.lane_squash = squash_s;
  assign cbus.flush_valid = flush_valid_r;
  assign cbus.flush_pc    = flush_pc_r;

endmodule

// File: tb/tb_cp0_commit_unit.sv
// Directed bench for cp0_commit_unit with a redirect scoreboard.
module tb_cp0_commit_unit;

  localparam int NL = 2;
  localparam int SYNC = 2;

  logic        clk;
  logic        resetn;
  logic [5:0]  ext_int;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        int_req;
  int          tests_run;
  int          tests_failed;
  logic [31:0] flush_q[$];
  logic        ti_found;
  logic [31:0] val;

  cp0_commit_unit_if #(.NUM_LANES(NL)) cbus ();

  cp0_commit_unit #(.NUM_LANES(NL), .COUNT_DIV(2), .SYNC_STAGES(SYNC)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .ext_int (ext_int),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .int_req (int_req),
    .cbus    (cbus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [4:0] a, input logic [31:0] exp);
    rd_addr = a;
    #1;
    check(tag, rd_data, exp);
  endtask

  task automatic clear_lanes();
    cbus.lane_valid = '0;           cbus.lane_exc_valid = '0;
    cbus.lane_exc_code = '0;        cbus.lane_delayed = '0;
    cbus.lane_pc = '0;              cbus.lane_bad_vaddr_valid = '0;
    cbus.lane_bad_vaddr = '0;       cbus.lane_eret = '0;
    cbus.lane_mtc0 = '0;            cbus.lane_mtc0_dst = '0;
    cbus.lane_mtc0_value = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clear_lanes();
    @(negedge clk);
  endtask

  task automatic drive_mtc0(input int l, input logic [4:0] dst, input logic [31:0] v);
    cbus.lane_valid[l] = 1'b1;
    cbus.lane_mtc0[l] = 1'b1;
    cbus.lane_mtc0_dst[l*5 +: 5] = dst;
    cbus.lane_mtc0_value[l*32 +: 32] = v;
  endtask

  task automatic drive_exc(input int l, input logic [4:0] code, input logic [31:0] pc,
                           input logic dly, input logic bvv, input logic [31:0] bv);
    cbus.lane_valid[l] = 1'b1;
    cbus.lane_exc_valid[l] = 1'b1;
    cbus.lane_exc_code[l*5 +: 5] = code;
    cbus.lane_pc[l*32 +: 32] = pc;
    cbus.lane_delayed[l] = dly;
    cbus.lane_bad_vaddr_valid[l] = bvv;
    cbus.lane_bad_vaddr[l*32 +: 32] = bv;
  endtask

  task automatic drive_eret(input int l);
    cbus.lane_valid[l] = 1'b1;
    cbus.lane_eret[l] = 1'b1;
  endtask

  task automatic expect_flush(input string tag);
    check({tag, "_valid"}, {31'd0, cbus.flush_valid}, 32'd1);
    check({tag, "_pending"}, 32'(flush_q.size()), 32'd1);
    if (flush_q.size() > 0) begin
      val = flush_q.pop_front();
      check({tag, "_pc"}, cbus.flush_pc, val);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    resetn = 1'b0;
    ext_int = 6'd0;
    rd_addr = 5'd0;
    clear_lanes();
    repeat (2) @(negedge clk);
    check("rst_flush", {31'd0, cbus.flush_valid}, 32'd0);
    check("rst_int_req", {31'd0, int_req}, 32'd0);
    resetn = 1'b1;

    // Idle timer: 10 cycles at COUNT_DIV=2.
    repeat (10) step();
    chk_reg("idle_count", 5'd9, 32'd5);
    chk_reg("idle_status", 5'd12, 32'h0040_0000);
    chk_reg("idle_cause", 5'd13, 32'd0);
    chk_reg("unimpl_reg", 5'd3, 32'd0);
    check("idle_int_req", {31'd0, int_req}, 32'd0);

    // Timer interrupt.
    drive_mtc0(0, 5'd12, 32'h0040_8001);
    drive_mtc0(1, 5'd9, 32'd0);
    step();
    drive_mtc0(0, 5'd11, 32'd3);
    step();
    ti_found = 1'b0;
    for (int k = 0; k < 20 && !ti_found; k++) begin
      rd_addr = 5'd13;
      #1;
      if (rd_data[30]) ti_found = 1'b1;
      else step();
    end
    check("ti_set", {31'd0, ti_found}, 32'd1);
    chk_reg("ti_count", 5'd9, 32'd3);
    check("ti_int_req_lag", {31'd0, int_req}, 32'd0);
    step();
    check("ti_int_req", {31'd0, int_req}, 32'd1);
    drive_mtc0(0, 5'd11, 32'd100);
    step();
    rd_addr = 5'd13;
    #1;
    check("ti_clear", {31'd0, rd_data[30]}, 32'd0);
    check("int_req_hold", {31'd0, int_req}, 32'd1);
    step();
    check("int_req_fall", {31'd0, int_req}, 32'd0);

    // Older MTC0 EPC plus younger AdEL in a delay slot.
    drive_mtc0(0, 5'd14, 32'h0000_1234);
    drive_exc(1, 5'd4, 32'hBFC0_0010, 1'b1, 1'b1, 32'h0000_0005);
    #1;
    check("adel_squash", 32'(cbus.lane_squash), 32'd0);
    flush_q.push_back(32'hBFC0_0380);
    step();
    expect_flush("adel_flush");
    chk_reg("adel_epc", 5'd14, 32'hBFC0_000C);
    chk_reg("adel_cause", 5'd13, 32'h8000_0010);
    chk_reg("adel_badva", 5'd8, 32'h0000_0005);
    chk_reg("adel_status", 5'd12, 32'h0040_8003);
    step();
    check("adel_one_cycle", {31'd0, cbus.flush_valid}, 32'd0);

    drive_eret(0);
    flush_q.push_back(32'hBFC0_000C);
    step();
    expect_flush("eret1");
    chk_reg("eret1_status", 5'd12, 32'h0040_8001);

    // Sys on lane 0 squashes lane 1 MTC0 Status.
    drive_exc(0, 5'd8, 32'h8000_1000, 1'b0, 1'b0, 32'd0);
    drive_mtc0(1, 5'd12, 32'd0);
    #1;
    check("sys_squash", 32'(cbus.lane_squash), 32'd2);
    flush_q.push_back(32'hBFC0_0380);
    step();
    expect_flush("sys_flush");
    chk_reg("sys_status", 5'd12, 32'h0040_8003);
    chk_reg("sys_epc", 5'd14, 32'h8000_1000);
    chk_reg("sys_cause", 5'd13, 32'h0000_0020);

    // Nested exception keeps EPC/BD.
    drive_exc(0, 5'd12, 32'h8000_2000, 1'b1, 1'b0, 32'd0);
    flush_q.push_back(32'hBFC0_0380);
    step();
    expect_flush("nest_flush");
    chk_reg("nest_epc", 5'd14, 32'h8000_1000);
    chk_reg("nest_cause", 5'd13, 32'h0000_0030);
    chk_reg("nest_badva", 5'd8, 32'h0000_0005);
    drive_eret(0);
    flush_q.push_back(32'h8000_1000);
    step();
    expect_flush("eret2");
    chk_reg("eret2_status", 5'd12, 32'h0040_8001);

    // ERET on lane 1 sees lane 0's EPC write.
    drive_mtc0(0, 5'd14, 32'h8000_4000);
    drive_eret(1);
    #1;
    check("eret3_squash", 32'(cbus.lane_squash), 32'd0);
    flush_q.push_back(32'h8000_4000);
    step();
    expect_flush("eret3");
    chk_reg("eret3_epc", 5'd14, 32'h8000_4000);

    // Invalid lane ignored; same-register MTC0 younger lane wins.
    cbus.lane_exc_valid[0] = 1'b1;
    cbus.lane_exc_code[4:0] = 5'd10;
    drive_mtc0(1, 5'd30, 32'h0000_0022);
    step();
    check("invalid_no_flush", {31'd0, cbus.flush_valid}, 32'd0);
    chk_reg("invalid_cause", 5'd13, 32'h0000_0030);
    drive_mtc0(0, 5'd30, 32'h0000_0011);
    drive_mtc0(1, 5'd30, 32'h0000_0033);
    step();
    chk_reg("errorepc_order", 5'd30, 32'h0000_0033);

    // IV=1, then external interrupt latency.
    drive_mtc0(0, 5'd13, 32'h0080_0000);
    step();
    chk_reg("iv_cause", 5'd13, 32'h0080_0030);
    ext_int = 6'b000100;
    step();
    step();
    chk_reg("ip4_early", 5'd13, 32'h0080_0030);
    step();
    chk_reg("ip4_rise", 5'd13, 32'h0080_1030);
    check("ip4_no_int_req", {31'd0, int_req}, 32'd0);

    // Int exception with IV=1, then reset during the redirect pulse.
    drive_exc(0, 5'd0, 32'h8000_5000, 1'b0, 1'b0, 32'd0);
    flush_q.push_back(32'hBFC0_0400);
    step();
    expect_flush("int_flush");
    resetn = 1'b0;
    #1;
    check("rst_mid_flush", {31'd0, cbus.flush_valid}, 32'd0);
    chk_reg("rst_cause", 5'd13, 32'd0);
    chk_reg("rst_status", 5'd12, 32'h0040_0000);
    chk_reg("rst_epc", 5'd14, 32'd0);
    ext_int = 6'd0;
    check("queue_empty", 32'(flush_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
